// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a three-digit common-anode
// seven-segment score display.
// - Each digit slot opens with a dead-time gap.
// - A tear-free BCD snapshot is taken at every frame boundary.
// - The whole display blinks while the game is over.
// Optional feature macro: SEG_LEAD_ZERO_BLANK_EN (leading-zero blanking of
// the hundreds and tens digits). Leave it undefined to show all three digits.

module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,  // clock cycles per digit slot (>= 4)
  parameter int BLANK_CYC    = 500,    // dead-time cycles per slot (1..SCAN_DIV-1)
  parameter int BLINK_FRAMES = 128     // frames per blink half-period (>= 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_data,
  input  logic [1:0]  game_status,
  output logic [7:0]  seg,
  output logic [2:0]  sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [FW-1:0] FRM_ZERO  = FW'(0);
  localparam logic [FW-1:0] FRM_ONE   = FW'(1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  localparam logic [1:0] ST_RESTART  = 2'b00;
  localparam logic [1:0] ST_GAMEOVER = 2'b11;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [2:0] SEL_OFF = 3'b111;

  // Active-low glyph for one BCD nibble; anything above 9 shows a dash.
  function automatic logic [7:0] f_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = 8'hBF;
    endcase
    return g;
  endfunction

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [11:0]   r_shadow;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [7:0]    r_seg;
  logic [2:0]    r_sel;

  logic          w_cnt_wrap;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_in_blank;
  logic          w_restart;
  logic          w_gameover;
  logic [11:0]   w_shadow_eff;
  logic [3:0]    w_nibble;
  logic [2:0]    w_sel_drive;
  logic          w_lz_blank;
  logic [7:0]    w_seg_nxt;
  logic [2:0]    w_sel_nxt;

  assign w_cnt_wrap    = (r_cnt == CNT_LAST);
  assign w_frame_start = (r_cnt == CNT_ZERO) && (r_idx == 2'd0);
  assign w_frame_end   = w_cnt_wrap && (r_idx == 2'd2);
  assign w_in_blank    = (r_cnt < CNT_BLANK);
  assign w_restart     = (game_status == ST_RESTART);
  assign w_gameover    = (game_status == ST_GAMEOVER);
  // RESTART forces a zero score straight into the output path, so the glyph
  // reacts on the very next edge rather than one cycle after the shadow.
  assign w_shadow_eff  = w_restart ? 12'h000 : r_shadow;

  // Pick the shadow nibble and the active-low digit enable for the current slot.
  always_comb begin
    w_nibble    = 4'hF;
    w_sel_drive = SEL_OFF;
    case (r_idx)
      2'd0: begin
        w_nibble    = w_shadow_eff[3:0];
        w_sel_drive = 3'b110;
      end
      2'd1: begin
        w_nibble    = w_shadow_eff[7:4];
        w_sel_drive = 3'b101;
      end
      2'd2: begin
        w_nibble    = w_shadow_eff[11:8];
        w_sel_drive = 3'b011;
      end
      default: begin
        w_nibble    = 4'hF;
        w_sel_drive = SEL_OFF;
      end
    endcase
  end

  // Decide whether the current digit is a suppressed leading zero.
  always_comb begin
    w_lz_blank = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    // A dash nibble is non-zero, so it never counts as a leading zero.
    case (r_idx)
      2'd2:    w_lz_blank = (w_shadow_eff[11:8] == 4'h0);
      2'd1:    w_lz_blank = (w_shadow_eff[11:4] == 8'h00);
      default: w_lz_blank = 1'b0;
    endcase
`else
    w_lz_blank = 1'b0;
`endif
  end

  // Next segment/enable pattern: dead time and the blink-off half look identical.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_sel_nxt = SEL_OFF;
    if (w_in_blank || r_blink_phase) begin
      w_seg_nxt = SEG_OFF;
      w_sel_nxt = SEL_OFF;
    end else begin
      w_sel_nxt = w_sel_drive;
      if (w_lz_blank) begin
        w_seg_nxt = SEG_OFF;
      end else begin
        w_seg_nxt = f_glyph(w_nibble);
      end
    end
  end

  // Slot counter and digit index; the index steps when the slot counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
      r_idx <= 2'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= CNT_ZERO;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
      r_idx <= r_idx;
    end
  end

  // Score snapshot: taken at each frame boundary, held at zero during RESTART.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 12'h000;
    end else if (w_restart) begin
      r_shadow <= 12'h000;
    end else if (w_frame_start) begin
      r_shadow <= bcd_data;
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Blink timing: count completed frames in GAMEOVER, flip phase every BLINK_FRAMES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= FRM_ZERO;
      r_blink_phase <= 1'b0;
    end else if (!w_gameover) begin
      r_frame_cnt   <= FRM_ZERO;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRM_LAST) begin
        r_frame_cnt   <= FRM_ZERO;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + FRM_ONE;
        r_blink_phase <= r_blink_phase;
      end
    end else begin
      r_frame_cnt   <= r_frame_cnt;
      r_blink_phase <= r_blink_phase;
    end
  end

  // Register seg and sel together so a digit enable never meets another digit's glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_sel <= w_sel_nxt;
    end
  end

  assign seg = r_seg;
  assign sel = r_sel;

endmodule
